multicycle_control: RTL
=======================

# multicycle_control

Main control finite state machine (FSM) for the multi-cycle MIPS datapath. It sits directly upstream of the ALU control decoder. It decodes the instruction opcode and sequences each instruction over several clock cycles. In every cycle it drives the datapath enables, the mux selects, and the 2-bit `ALUOp` consumed by the ALU control decoder. It also handles a simple memory-ready handshake, so that memory stalls hold the FSM in place.

## Interface
- No parameters; all encodings are fixed constants in the package.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `Op` input 6: `instr[31:26]`, valid from the DECODE state onward (taken from the instruction register).
- `Zero` input 1: ALU zero flag.
- `MemReady` input 1: memory has completed the current access this cycle.
- `MemtoReg`, `RegDst`, `IorD`, `ALUSrcA`, `IRWrite`, `MemWrite`, `RegWrite`, `Branch`, `PCWrite` output 1 each: datapath controls.
- `PCSrc` output 2: PC source select. 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUSrcB` output 2: ALU B select. 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp` output 2: 00 = add, 01 = sub, 10 = decode `funct`. Feeds the ALU control decoder.
- `PCEn` output 1: `PCWrite | (Branch & Zero)`.
- `InstrDone` output 1: one-cycle pulse in the final cycle of each instruction.
- `IllegalOp` output 1: high in DECODE when `Op` is unsupported.
- `State` output 4: current state, for debug and the bench.

## Operation
- Outputs are a Moore decode of `State`, except for these combinational terms: `PCEn`, the `MemReady` gating, and `IllegalOp`. Any output not listed for a state is 0.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- States, their outputs, and the next state:
  - FETCH(0): `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSrc`=00. `IRWrite` and `PCWrite` = `MemReady`. Holds while `MemReady`=0; otherwise goes to DECODE.
  - DECODE(1): `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. Next state by opcode: lw/sw → MEMADR, R-type → RTYPEEX, beq → BEQEX, addi → ADDIEX, j → JEX. Any other opcode → FETCH, with `IllegalOp`=1.
  - MEMADR(2): `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): `IorD`=1. Holds until `MemReady`, then goes to MEMWB.
  - MEMWB(4): `RegDst`=0, `MemtoReg`=1, `RegWrite`=1, `InstrDone`=1. Goes to FETCH.
  - MEMWR(5): `IorD`=1, `MemWrite`=1 (held while waiting). Holds until `MemReady`; then `InstrDone`=1 and goes to FETCH.
  - RTYPEEX(6): `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Goes to RTYPEWB.
  - RTYPEWB(7): `RegDst`=1, `MemtoReg`=0, `RegWrite`=1, `InstrDone`=1. Goes to FETCH.
  - BEQEX(8): `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCSrc`=01, `Branch`=1, `InstrDone`=1. Goes to FETCH.
  - ADDIEX(9): `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Goes to ADDIWB.
  - ADDIWB(10): `RegDst`=0, `MemtoReg`=0, `RegWrite`=1, `InstrDone`=1. Goes to FETCH.
  - JEX(11): `PCSrc`=10, `PCWrite`=1, `InstrDone`=1. Goes to FETCH.
- Encodings 12–15 are unreachable. If they are ever entered, all outputs are 0 and the next state is FETCH.

## Timing
- Reset:
  - While `reset`=1, every output is forced to 0, including `PCEn` and `State`.
  - On a clock edge with `reset`=1, `State` becomes FETCH.
  - The first cycle after deassertion is FETCH.
  - Reset mid-instruction aborts the instruction on the next edge. No write enable is asserted in the reset cycle.
- Latency in cycles, with `MemReady` always 1:
  - lw 5
  - sw 4
  - R-type 4
  - beq 3
  - addi 4
  - j 3
  - illegal opcode 2
- Each cycle that `MemReady` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. During that wait, `IRWrite`, `PCWrite` and `InstrDone` stay 0.
- `Zero` is sampled only combinationally in BEQEX. `PCEn` is 1 in that cycle if and only if `Zero`=1.

## Configuration
- Macro: `MULTICYCLE_CONTROL_JUMP_EN`.
- Defined: j (000010) is supported through JEX.
- Undefined: the JEX state and `PCSrc`=10 are compiled out. Opcode 000010 is treated as illegal (DECODE → FETCH with `IllegalOp`=1). The `PCSrc` port keeps its 2-bit width.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants;
  - the `ALUOp` encodings (00/01/10);
  - the `ALUSrcB` and `PCSrc` select encodings;
  - the 4-bit state typedef with the named state constants.
- One sub-module is natural: `mc_state_decode`, a combinational decode from state to control word. The parent module keeps the state register, the next-state logic, the `MemReady` gating, and `PCEn`.

## Test plan
- Reset, then `Op`=100011 (lw) with `MemReady`=1. Expect `State` to follow 0,1,2,3,4,0. Expect `RegWrite`=1 and `MemtoReg`=1 only in state 4, and `InstrDone` exactly once.
- R-type (`Op`=000000). Expect `ALUOp`=10 with `ALUSrcA`=1 in state 6. Expect `RegDst`=1 and `RegWrite`=1 in state 7. Latency 4.
- beq, run twice:
  - with `Zero`=1: `PCEn`=1 in state 8 with `PCSrc`=01;
  - with `Zero`=0: `PCEn`=0.
- sw with `MemReady` low for 3 cycles in MEMWR. Expect `MemWrite` held high for 4 cycles and `InstrDone` only on the ready cycle. Total latency 7.
- Apply `reset`=1 in ADDIEX. Expect all outputs 0 in that cycle and `State`=0 on the next edge. Expect no `RegWrite` from the aborted addi.
- `Op`=111111. Expect `IllegalOp`=1 in DECODE, then FETCH. Repeat with `Op`=000010 with the macro undefined; expect the same response.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, select codes, FSM states.
// MULTICYCLE_CONTROL_JUMP_EN adds the j instruction (JEX state, PCSrc jump target).
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      , S_JEX   = 4'd11
`endif
   } state_t;

   typedef struct packed {
      logic [1:0] pcsrc;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       memtoreg;
      logic       regdst;
      logic       iord;
      logic       alusrca;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       branch;
      logic       pcwrite;
      logic       instrdone;
   } ctrl_t;

endpackage

// File: rtl/mc_state_decode.sv
// Pure Moore decode from FSM state to the raw datapath control word (before MemReady gating).
// MULTICYCLE_CONTROL_JUMP_EN enables the JEX row.
module mc_state_decode
   import mips_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.pcsrc   = PCSRC_ALU;
            ctrl.irwrite = 1'b1;
            ctrl.pcwrite = 1'b1;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMM4;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.memtoreg  = 1'b1;
            ctrl.regwrite  = 1'b1;
            ctrl.instrdone = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.memwrite  = 1'b1;
            ctrl.instrdone = 1'b1;
         end
         S_RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            ctrl.regdst    = 1'b1;
            ctrl.regwrite  = 1'b1;
            ctrl.instrdone = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = SRCB_REG;
            ctrl.aluop     = ALUOP_SUB;
            ctrl.pcsrc     = PCSRC_ALUOUT;
            ctrl.branch    = 1'b1;
            ctrl.instrdone = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.regwrite  = 1'b1;
            ctrl.instrdone = 1'b1;
         end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
         S_JEX: begin
            ctrl.pcsrc     = PCSRC_JUMP;
            ctrl.pcwrite   = 1'b1;
            ctrl.instrdone = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register, next-state, MemReady gating, PCEn.
// MULTICYCLE_CONTROL_JUMP_EN enables j (opcode 000010); otherwise it is decoded as illegal.
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       Branch,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       PCEn,
   output logic       InstrDone,
   output logic       IllegalOp,
   output logic [3:0] State
);

   state_t state, state_nxt;
   ctrl_t  raw, ctrl;
   logic   mem_wait;
   logic   illegal;

   mc_state_decode u_decode (.state(state), .ctrl(raw));

   // Handshake: a memory access completes in any cycle MemReady is high; while it is low
   // the FSM holds in FETCH/MEMRD/MEMWR and suppresses IRWrite, PCWrite and InstrDone.
   always_comb begin
      state_nxt = S_FETCH;
      illegal   = 1'b0;
      case (state)
         S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_RTYPEEX;
               OP_BEQ:       state_nxt = S_BEQEX;
               OP_ADDI:      state_nxt = S_ADDIEX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
               OP_J:         state_nxt = S_JEX;
`endif
               default: begin
                  state_nxt = S_FETCH;
                  illegal   = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_nxt = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_nxt = MemReady ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_nxt = S_RTYPEWB;
         S_ADDIEX:  state_nxt = S_ADDIWB;
         default:   state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      ctrl     = raw;
      mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !MemReady;
      if (mem_wait) begin
         ctrl.irwrite   = 1'b0;
         ctrl.pcwrite   = 1'b0;
         ctrl.instrdone = 1'b0;
      end
      if (reset) ctrl = '0;
   end

   assign MemtoReg  = ctrl.memtoreg;
   assign RegDst    = ctrl.regdst;
   assign IorD      = ctrl.iord;
   assign ALUSrcA   = ctrl.alusrca;
   assign IRWrite   = ctrl.irwrite;
   assign MemWrite  = ctrl.memwrite;
   assign RegWrite  = ctrl.regwrite;
   assign Branch    = ctrl.branch;
   assign PCWrite   = ctrl.pcwrite;
   assign PCSrc     = ctrl.pcsrc;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ALUOp     = ctrl.aluop;
   assign InstrDone = ctrl.instrdone;
   assign PCEn      = ctrl.pcwrite | (ctrl.branch & Zero);
   assign IllegalOp = illegal & !reset;
   assign State     = reset ? 4'd0 : state;

endmodule
